// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// One requester is served at a time, with round-robin tie-break, misalignment errors and a wait timeout.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_D  = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam int CW     = $clog2(MAX_WAIT + 2);
  localparam int TO_VAL = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TO_VAL);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;  // 0 = fetch, 1 = data
  logic [CW-1:0]     r_wait_cnt;
  logic              r_m_req, r_m_we, r_busy;
  logic [1:0]        r_m_size;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_if_ack, r_if_err, r_d_ack, r_d_err;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;

  logic              w_last_grant;
  logic [CW-1:0]     w_wait_cnt;
  logic              w_m_req, w_m_we, w_busy;
  logic [1:0]        w_m_size;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_wdata;
  logic              w_if_ack, w_if_err, w_d_ack, w_d_err;
  logic [DATA_W-1:0] w_if_rdata, w_d_rdata;

  logic w_sel_d, w_sel_if, w_d_mis, w_if_mis, w_timeout;

  // On contention the requester that did not win last time is chosen.
  assign w_sel_d   = d_req & (~if_req | ~r_last_grant);
  assign w_sel_if  = if_req & ~w_sel_d;
  assign w_d_mis   = ((d_size == 2'b01) & d_addr[0]) |
                     ((d_size == 2'b10) & (d_addr[1:0] != 2'b00)) |
                     (d_size == 2'b11);
  assign w_if_mis  = (if_addr[1:0] != 2'b00);
  assign w_timeout = (MAX_WAIT != 0) && (r_wait_cnt == TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b0;
      r_wait_cnt   <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_size     <= 2'b00;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_if_ack     <= 1'b0;
      r_if_err     <= 1'b0;
      r_if_rdata   <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_last_grant;
      r_wait_cnt   <= w_wait_cnt;
      r_m_req      <= w_m_req;
      r_m_we       <= w_m_we;
      r_m_size     <= w_m_size;
      r_m_addr     <= w_m_addr;
      r_m_wdata    <= w_m_wdata;
      r_if_ack     <= w_if_ack;
      r_if_err     <= w_if_err;
      r_if_rdata   <= w_if_rdata;
      r_d_ack      <= w_d_ack;
      r_d_err      <= w_d_err;
      r_d_rdata    <= w_d_rdata;
      r_busy       <= w_busy;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_sel_d)       w_next_state = w_d_mis ? S_RESP : S_BUSY_D;
        else if (w_sel_if) w_next_state = w_if_mis ? S_RESP : S_BUSY_IF;
      end
      S_BUSY_IF, S_BUSY_D: begin
        if (m_ack || w_timeout) w_next_state = S_RESP;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values for every registered output; ack/err/rdata default to zero.
  always_comb begin
    w_last_grant = r_last_grant;
    w_wait_cnt   = r_wait_cnt;
    w_m_req      = r_m_req;
    w_m_we       = r_m_we;
    w_m_size     = r_m_size;
    w_m_addr     = r_m_addr;
    w_m_wdata    = r_m_wdata;
    w_if_ack     = 1'b0;
    w_if_err     = 1'b0;
    w_if_rdata   = '0;
    w_d_ack      = 1'b0;
    w_d_err      = 1'b0;
    w_d_rdata    = '0;
    w_busy       = (w_next_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (w_sel_d) begin
          w_last_grant = 1'b1;
          if (w_d_mis) begin
            w_d_ack = 1'b1;
            w_d_err = 1'b1;
          end else begin
            w_m_req    = 1'b1;
            w_m_we     = d_we;
            w_m_size   = d_size;
            w_m_addr   = d_addr;
            w_m_wdata  = d_wdata;
            w_wait_cnt = '0;
          end
        end else if (w_sel_if) begin
          w_last_grant = 1'b0;
          if (w_if_mis) begin
            w_if_ack = 1'b1;
            w_if_err = 1'b1;
          end else begin
            w_m_req    = 1'b1;
            w_m_we     = 1'b0;
            w_m_size   = 2'b10;
            w_m_addr   = if_addr;
            w_m_wdata  = '0;
            w_wait_cnt = '0;
          end
        end
      end
      S_BUSY_IF: begin
        if (m_ack) begin
          w_m_req    = 1'b0;
          w_if_ack   = 1'b1;
          w_if_rdata = m_rdata;
        end else begin
          w_wait_cnt = r_wait_cnt + CW'(1);
          if (w_timeout) begin
            w_m_req  = 1'b0;
            w_if_ack = 1'b1;
            w_if_err = 1'b1;
          end
        end
      end
      S_BUSY_D: begin
        if (m_ack) begin
          w_m_req   = 1'b0;
          w_d_ack   = 1'b1;
          w_d_rdata = r_m_we ? '0 : m_rdata;
        end else begin
          w_wait_cnt = r_wait_cnt + CW'(1);
          if (w_timeout) begin
            w_m_req = 1'b0;
            w_d_ack = 1'b1;
            w_d_err = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign if_rdata = r_if_rdata;
  assign if_ack   = r_if_ack;
  assign if_err   = r_if_err;
  assign d_rdata  = r_d_rdata;
  assign d_ack    = r_d_ack;
  assign d_err    = r_d_err;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_size   = r_m_size;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected acks are queued by the drivers and
// consumed by a monitor whenever if_ack or d_ack is seen.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, m_ack;
  logic [1:0]  d_size;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, if_err, d_ack, d_err, m_req, m_we, busy;
  logic [1:0]  m_size;

  logic        nt_if_req, nt_d_req, nt_d_we, nt_m_ack;
  logic [1:0]  nt_d_size;
  logic [31:0] nt_if_addr, nt_d_addr, nt_d_wdata, nt_m_rdata;
  logic [31:0] nt_if_rdata, nt_d_rdata, nt_m_addr, nt_m_wdata;
  logic        nt_if_ack, nt_if_err, nt_d_ack, nt_d_err, nt_m_req, nt_m_we, nt_busy;
  logic [1:0]  nt_m_size;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [33:0] exp_q[$];  // {is_data, err, rdata}

  int          mem_lat = 0;
  bit          mem_en = 1'b1;
  logic [31:0] mem_rdata = 32'h0;
  int          mem_cnt = 0;

  int          rises = 0, run_len = 0, last_len = 0;
  bit          prev_mreq = 1'b0;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)) u_dut_nt (
    .clk(clk), .rst(rst),
    .if_req(nt_if_req), .if_addr(nt_if_addr), .if_rdata(nt_if_rdata), .if_ack(nt_if_ack),
    .if_err(nt_if_err),
    .d_req(nt_d_req), .d_we(nt_d_we), .d_size(nt_d_size), .d_addr(nt_d_addr),
    .d_wdata(nt_d_wdata), .d_rdata(nt_d_rdata), .d_ack(nt_d_ack), .d_err(nt_d_err),
    .m_req(nt_m_req), .m_we(nt_m_we), .m_size(nt_m_size), .m_addr(nt_m_addr),
    .m_wdata(nt_m_wdata), .m_rdata(nt_m_rdata), .m_ack(nt_m_ack), .busy(nt_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks in the (mem_lat+1)-th cycle of m_req when enabled.
  always @(negedge clk) begin
    if (m_req && !rst) begin
      m_ack   = mem_en && (mem_cnt == mem_lat);
      m_rdata = m_ack ? mem_rdata : 32'hBAD0_BAD0;
      mem_cnt++;
    end else begin
      m_ack   = 1'b0;
      m_rdata = 32'hBAD0_BAD0;
      mem_cnt = 0;
    end
  end

  // Scoreboard monitor and memory-request tracker
  always @(negedge clk) begin
    logic [33:0] e;
    if (if_ack && d_ack) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL ack_overlap: if_ack=1 and d_ack=1 in same cycle");
    end
    if (if_ack || d_ack) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b with empty queue", if_ack, d_ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {63'd0, d_ack}, {63'd0, e[33]});
        check("ack_err", {63'd0, d_ack ? d_err : if_err}, {63'd0, e[32]});
        check("ack_rdata", {32'd0, d_ack ? d_rdata : if_rdata}, {32'd0, e[31:0]});
      end
    end
    if (m_req) begin
      if (!prev_mreq) begin
        rises++;
        cap_we    = m_we;
        cap_size  = m_size;
        cap_addr  = m_addr;
        cap_wdata = m_wdata;
      end
      run_len++;
    end else if (prev_mreq) begin
      last_len = run_len;
      run_len  = 0;
    end
    prev_mreq = m_req;
  end

  // Driver: issues one request, waits for its ack and checks latency and busy drop.
  task automatic run_req(input string name, input bit is_d, input logic we,
                         input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input bit en,
                         input logic [31:0] rd, input logic exp_err,
                         input logic [31:0] exp_rd, input int exp_lat);
    int n;
    bit got;
    exp_q.push_back({is_d, exp_err, exp_rd});
    mem_lat   = lat;
    mem_en    = en;
    mem_rdata = rd;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = is_d ? d_ack : if_ack;
    end
    d_req  = 1'b0;
    if_req = 1'b0;
    if (!got) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: no ack after %0d cycles", name, n);
      exp_q.delete();
    end else begin
      check({name, "_lat"}, 64'(n), 64'(exp_lat));
    end
    @(negedge clk);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n, r0, nt_acks;
    bit got_d, got_any;
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    nt_if_req = 0; nt_if_addr = 0; nt_d_req = 0; nt_d_we = 0; nt_d_size = 0;
    nt_d_addr = 0; nt_d_wdata = 0; nt_m_ack = 0; nt_m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_m_req", {63'd0, m_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_if_ack", {63'd0, if_ack}, 64'd0);
    check("rst_d_ack", {63'd0, d_ack}, 64'd0);
    check("rst_m_addr", {32'd0, m_addr}, 64'd0);
    check("rst_d_rdata", {32'd0, d_rdata}, 64'd0);

    // Conflict held from reset, zero-latency memory: order D, IF, D, IF
    mem_lat = 0; mem_en = 1'b1; mem_rdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h200;
    exp_q.push_back({1'b1, 1'b0, 32'h1234_5678});
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    exp_q.push_back({1'b1, 1'b0, 32'h1234_5678});
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    rst = 1'b0;
    r0 = 0;
    n = 0;
    while (r0 < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (if_ack || d_ack) r0++;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check("conflict_acks", 64'(r0), 64'd4);
    if (r0 != 4) exp_q.delete();
    repeat (2) @(negedge clk);

    // Single fetch, memory acks in third m_req cycle
    run_req("fetch", 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 2, 1'b1, 32'h13, 1'b0, 32'h13, 4);
    check("fetch_mreq_len", 64'(last_len), 64'd3);

    // Store: latched memory fields, zero read data
    run_req("store", 1'b1, 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF, 1, 1'b1, 32'h5555_AAAA,
            1'b0, 32'h0, 3);
    check("store_m_we", {63'd0, cap_we}, 64'd1);
    check("store_m_size", {62'd0, cap_size}, 64'd2);
    check("store_m_addr", {32'd0, cap_addr}, 64'h100);
    check("store_m_wdata", {32'd0, cap_wdata}, 64'hDEAD_BEEF);
    check("store_mreq_len", 64'(last_len), 64'd2);

    // Aligned halfword load, minimum latency
    run_req("half_ld", 1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 0, 1'b1, 32'hCAFE_F00D,
            1'b0, 32'hCAFE_F00D, 2);
    check("half_m_size", {62'd0, cap_size}, 64'd1);

    // Misaligned: acked next cycle with error, memory untouched
    r0 = rises;
    run_req("mis_half", 1'b1, 1'b0, 2'b01, 32'h101, 32'h0, 0, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 1);
    run_req("mis_word", 1'b1, 1'b1, 2'b10, 32'h102, 32'h9, 0, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 1);
    run_req("mis_sz11", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 0, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 1);
    run_req("mis_fetch", 1'b0, 1'b0, 2'b10, 32'h2, 32'h0, 0, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 1);
    check("mis_no_mreq", 64'(rises), 64'(r0));

    // Timeout with MAX_WAIT=4 and a silent memory
    run_req("tmo", 1'b0, 1'b0, 2'b10, 32'h80, 32'h0, 0, 1'b0, 32'h2222_2222, 1'b1, 32'h0, 5);
    check("tmo_mreq_len", 64'(last_len), 64'd4);
    check("tmo_addr_hold", {32'd0, m_addr}, 64'h80);

    // MAX_WAIT=0: request stays up indefinitely
    nt_if_addr = 32'h40;
    nt_if_req  = 1'b1;
    nt_acks = 0;
    repeat (300) begin
      @(negedge clk);
      if (nt_if_ack || nt_d_ack) nt_acks++;
    end
    check("nt_m_req", {63'd0, nt_m_req}, 64'd1);
    check("nt_no_ack", 64'(nt_acks), 64'd0);
    nt_if_req = 1'b0;

    // Reset in BUSY_D: no ack, then first conflict goes to data again
    mem_lat = 0; mem_en = 1'b0; mem_rdata = 32'h7777_0000;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h300;
    repeat (3) @(negedge clk);
    check("rstmid_pre_mreq", {63'd0, m_req}, 64'd1);
    rst = 1'b1;
    mem_en = 1'b1;
    @(negedge clk);
    check("rstmid_m_req", {63'd0, m_req}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_d_ack", {63'd0, d_ack}, 64'd0);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h44;
    exp_q.push_back({1'b1, 1'b0, 32'h7777_0000});
    got_any = 1'b0;
    got_d = 1'b0;
    n = 0;
    while (!got_any && n < 20) begin
      @(negedge clk);
      n++;
      got_any = if_ack || d_ack;
      got_d = d_ack;
    end
    d_req = 1'b0;
    if_req = 1'b0;
    check("rstmid_grant_d", {63'd0, got_d}, 64'd1);
    if (!got_any) exp_q.delete();
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
